// File: rtl/fx_writeback_queue_if.sv
// ---------------------------------------------------------------------------
// fx_writeback_queue_if
// GPR write-port bundle between the FX writeback queue and the register file.
//   gprWriteValid_o   : head entry has a GPR write pending (queue -> RF)
//   gprWriteAddress_o : destination GPR of the head entry      (queue -> RF)
//   gprWriteVal_o     : 64-bit write data of the head entry     (queue -> RF)
//   gprWriteReady_i   : register file accepts the write         (RF -> queue)
// Modports: master = writeback queue, slave = register file.
// ---------------------------------------------------------------------------
interface fx_writeback_queue_if #(
  parameter int regWidth = 5
);
  logic                gprWriteValid_o;
  logic [regWidth-1:0] gprWriteAddress_o;
  logic [63:0]         gprWriteVal_o;
  logic                gprWriteReady_i;

  modport master (
    output gprWriteValid_o,
    output gprWriteAddress_o,
    output gprWriteVal_o,
    input  gprWriteReady_i
  );

  modport slave (
    input  gprWriteValid_o,
    input  gprWriteAddress_o,
    input  gprWriteVal_o,
    output gprWriteReady_i
  );
endinterface

// File: rtl/fx_writeback_queue.sv
// ---------------------------------------------------------------------------
// fx_writeback_queue
// In-order FIFO between the FX stage-2 result registers and the GPR write
// port. Entries retire one per cycle from the head; at retire the
// architectural XER bits (SO/OV/CA) are updated and a CR0 write is issued
// on the following cycle. Dispatch is stalled early because the FX pipe
// cannot stall itself.
//
// Ports:
//   clock_i, reset_i (async, active low)
//   resultValid_i, functionalUnitCode_i, regWriteEnable_i,
//   regWriteAddress_i, regWriteVal_i, updateCR0_i, CR0_i,
//   updateOV_i, OV_i, updateCA_i, CA_i          : FX result input
//   wb (fx_writeback_queue_if.master)          : GPR write port
//   crWriteEnable_o, crField0_o                 : CR0 field write
//   xerSO_o, xerOV_o, xerCA_o                   : architectural XER bits
//   stall_o, overflowErr_o, count_o             : flow control / status
//
// Optional: define FXWB_FORWARD_EN to add forwardAddr_i / forwardHit_o /
// forwardVal_o, a combinational lookup of the youngest pending GPR write.
// ---------------------------------------------------------------------------
module fx_writeback_queue #(
  parameter int DEPTH        = 4,
  parameter int PTR_W        = 2,
  parameter int regWidth     = 5,
  parameter int STALL_MARGIN = 2
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                resultValid_i,
  input  logic [2:0]          functionalUnitCode_i,
  input  logic                regWriteEnable_i,
  input  logic [regWidth-1:0] regWriteAddress_i,
  input  logic [63:0]         regWriteVal_i,
  input  logic                updateCR0_i,
  input  logic [3:0]          CR0_i,
  input  logic                updateOV_i,
  input  logic                OV_i,
  input  logic                updateCA_i,
  input  logic                CA_i,
  fx_writeback_queue_if.master wb,
  output logic                crWriteEnable_o,
  output logic [3:0]          crField0_o,
  output logic                xerSO_o,
  output logic                xerOV_o,
  output logic                xerCA_o,
  output logic                stall_o,
  output logic                overflowErr_o,
`ifdef FXWB_FORWARD_EN
  input  logic [regWidth-1:0] forwardAddr_i,
  output logic                forwardHit_o,
  output logic [63:0]         forwardVal_o,
`endif
  output logic [PTR_W:0]      count_o
);

  // CR0 bit ordering is big-endian: CR0_i[3:1] = LT,GT,EQ; CR0_i[0] is
  // replaced by SO on the way out and is therefore not stored.
  typedef struct packed {
    logic                we;
    logic [regWidth-1:0] addr;
    logic [63:0]         val;
    logic                upd_cr0;
    logic [2:0]          cr0;
    logic                upd_ov;
    logic                ov;
    logic                upd_ca;
    logic                ca;
  } entry_t;

  entry_t              mem [DEPTH];
  entry_t              entry_in_p0;
  entry_t              head_p0;
  logic [PTR_W-1:0]    head_q;
  logic [PTR_W-1:0]    tail_q;
  logic [PTR_W:0]      count_q;
  logic [PTR_W:0]      count_next;
  logic [PTR_W:0]      free_next;
  logic                head_valid_p0;
  logic                accept_p0;
  logic                full_p0;
  logic                retire_p0;
  logic                enq_p0;
  logic                drop_p0;
  logic                so_next_p0;
  logic                unused_cr0_lsb;

  assign unused_cr0_lsb = CR0_i[0];

  // ---- stage p0: enqueue / retire decision ----
  assign entry_in_p0 = '{we:      regWriteEnable_i,
                         addr:    regWriteAddress_i,
                         val:     regWriteVal_i,
                         upd_cr0: updateCR0_i,
                         cr0:     CR0_i[3:1],
                         upd_ov:  updateOV_i,
                         ov:      OV_i,
                         upd_ca:  updateCA_i,
                         ca:      CA_i};

  assign head_p0       = mem[head_q];
  assign head_valid_p0 = (count_q != '0);
  assign full_p0       = (count_q == (PTR_W+1)'(DEPTH));
  assign accept_p0     = resultValid_i && (functionalUnitCode_i == 3'd0);
  // Non-GPR entries never wait on the register file.
  assign retire_p0     = head_valid_p0 && (!head_p0.we || wb.gprWriteReady_i);
  // A retire in the same cycle frees the slot the new entry lands in.
  assign enq_p0        = accept_p0 && (!full_p0 || retire_p0);
  assign drop_p0       = accept_p0 && full_p0 && !retire_p0;

  assign count_next = count_q + (PTR_W+1)'(enq_p0) - (PTR_W+1)'(retire_p0);
  assign free_next  = (PTR_W+1)'(DEPTH) - count_next;

  // CR0 reports SO as it stands after this entry's own OV update.
  assign so_next_p0 = xerSO_o | (head_p0.upd_ov & head_p0.ov);

  assign wb.gprWriteValid_o   = head_valid_p0 & head_p0.we;
  assign wb.gprWriteAddress_o = head_p0.addr;
  assign wb.gprWriteVal_o     = head_p0.val;
  assign count_o              = count_q;

  // ---- stage p1: storage and architectural state ----
  always_ff @(posedge clock_i) begin
    if (enq_p0) begin
      mem[tail_q] <= entry_in_p0;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      xerSO_o         <= 1'b0;
      xerOV_o         <= 1'b0;
      xerCA_o         <= 1'b0;
      crWriteEnable_o <= 1'b0;
      crField0_o      <= 4'b0000;
      stall_o         <= 1'b0;
      overflowErr_o   <= 1'b0;
    end else begin
      count_q         <= count_next;
      stall_o         <= (free_next <= (PTR_W+1)'(STALL_MARGIN));
      crWriteEnable_o <= retire_p0 && head_p0.upd_cr0;
      if (enq_p0) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (drop_p0) begin
        overflowErr_o <= 1'b1;
      end
      if (retire_p0) begin
        head_q <= head_q + PTR_W'(1);
        if (head_p0.upd_ca) begin
          xerCA_o <= head_p0.ca;
        end
        if (head_p0.upd_ov) begin
          xerOV_o <= head_p0.ov;
          xerSO_o <= so_next_p0;
        end
        if (head_p0.upd_cr0) begin
          crField0_o <= {head_p0.cr0, so_next_p0};
        end
      end
    end
  end

`ifdef FXWB_FORWARD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    forwardHit_o = 1'b0;
    forwardVal_o = '0;
    fwd_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_q) && mem[fwd_idx].we &&
          (mem[fwd_idx].addr == forwardAddr_i)) begin
        forwardHit_o = 1'b1;
        forwardVal_o = mem[fwd_idx].val;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fx_writeback_queue.sv
module tb_fx_writeback_queue;
  logic        clock_i;
  logic        reset_i;
  logic        resultValid_i;
  logic [2:0]  functionalUnitCode_i;
  logic        regWriteEnable_i;
  logic [4:0]  regWriteAddress_i;
  logic [63:0] regWriteVal_i;
  logic        updateCR0_i;
  logic [3:0]  CR0_i;
  logic        updateOV_i;
  logic        OV_i;
  logic        updateCA_i;
  logic        CA_i;
  logic        crWriteEnable_o;
  logic [3:0]  crField0_o;
  logic        xerSO_o;
  logic        xerOV_o;
  logic        xerCA_o;
  logic        stall_o;
  logic        overflowErr_o;
  logic [2:0]  count_o;
`ifdef FXWB_FORWARD_EN
  logic [4:0]  forwardAddr_i;
  logic        forwardHit_o;
  logic [63:0] forwardVal_o;
`endif

  int checks = 0;
  int errors = 0;

  fx_writeback_queue_if #(.regWidth(5)) wb ();

  fx_writeback_queue #(
    .DEPTH(4), .PTR_W(2), .regWidth(5), .STALL_MARGIN(2)
  ) dut (
    .clock_i              (clock_i),
    .reset_i              (reset_i),
    .resultValid_i        (resultValid_i),
    .functionalUnitCode_i (functionalUnitCode_i),
    .regWriteEnable_i     (regWriteEnable_i),
    .regWriteAddress_i    (regWriteAddress_i),
    .regWriteVal_i        (regWriteVal_i),
    .updateCR0_i          (updateCR0_i),
    .CR0_i                (CR0_i),
    .updateOV_i           (updateOV_i),
    .OV_i                 (OV_i),
    .updateCA_i           (updateCA_i),
    .CA_i                 (CA_i),
    .wb                   (wb),
    .crWriteEnable_o      (crWriteEnable_o),
    .crField0_o           (crField0_o),
    .xerSO_o              (xerSO_o),
    .xerOV_o              (xerOV_o),
    .xerCA_o              (xerCA_o),
    .stall_o              (stall_o),
    .overflowErr_o        (overflowErr_o),
`ifdef FXWB_FORWARD_EN
    .forwardAddr_i        (forwardAddr_i),
    .forwardHit_o         (forwardHit_o),
    .forwardVal_o         (forwardVal_o),
`endif
    .count_o              (count_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs and checks happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] addr, input logic [63:0] val,
                       input logic ucr, input logic [3:0] cr,
                       input logic uov, input logic ov, input logic uca, input logic ca);
    resultValid_i        = 1'b1;
    functionalUnitCode_i = 3'd0;
    regWriteEnable_i     = we;
    regWriteAddress_i    = addr;
    regWriteVal_i        = val;
    updateCR0_i          = ucr;
    CR0_i                = cr;
    updateOV_i           = uov;
    OV_i                 = ov;
    updateCA_i           = uca;
    CA_i                 = ca;
  endtask

  task automatic idle();
    resultValid_i = 1'b0;
    updateCR0_i   = 1'b0;
    updateOV_i    = 1'b0;
    updateCA_i    = 1'b0;
  endtask

  initial begin
    reset_i              = 1'b0;
    resultValid_i        = 1'b0;
    functionalUnitCode_i = 3'd0;
    regWriteEnable_i     = 1'b0;
    regWriteAddress_i    = 5'd0;
    regWriteVal_i        = 64'd0;
    updateCR0_i          = 1'b0;
    CR0_i                = 4'd0;
    updateOV_i           = 1'b0;
    OV_i                 = 1'b0;
    updateCA_i           = 1'b0;
    CA_i                 = 1'b0;
    wb.gprWriteReady_i   = 1'b1;
`ifdef FXWB_FORWARD_EN
    forwardAddr_i        = 5'd0;
`endif

    // Reset state
    tick(); tick();
    chk("rst_gprvalid", wb.gprWriteValid_o, 0);
    chk("rst_crwe", crWriteEnable_o, 0);
    chk("rst_crfield", crField0_o, 0);
    chk("rst_so", xerSO_o, 0);
    chk("rst_ov", xerOV_o, 0);
    chk("rst_ca", xerCA_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_ovf", overflowErr_o, 0);
    chk("rst_count", count_o, 0);
    reset_i = 1'b1;
    tick();

    // Single add into empty FIFO, ready=1
    drive(1, 5'd5, 64'h10, 0, 4'd0, 0, 0, 0, 0);
    tick();
    idle();
    chk("add_valid", wb.gprWriteValid_o, 1);
    chk("add_addr", wb.gprWriteAddress_o, 5);
    chk("add_val", wb.gprWriteVal_o, 64'h10);
    chk("add_count1", count_o, 1);
    tick();
    chk("add_count0", count_o, 0);
    chk("add_valid0", wb.gprWriteValid_o, 0);
    chk("add_crwe0", crWriteEnable_o, 0);

    // Full with simultaneous retire
    wb.gprWriteReady_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(11 + i), 64'(32'hB0 + i), 0, 4'd0, 0, 0, 0, 0);
      tick();
    end
    chk("full_count4", count_o, 4);
    chk("full_head11", wb.gprWriteAddress_o, 11);
    drive(1, 5'd15, 64'hB4, 0, 4'd0, 0, 0, 0, 0);
    wb.gprWriteReady_i = 1'b1;
    tick();
    idle();
    chk("simul_count", count_o, 4);
    chk("simul_ovf", overflowErr_o, 0);
    chk("simul_head12", wb.gprWriteAddress_o, 12);
    tick();
    chk("simul_head13", wb.gprWriteAddress_o, 13);
    tick();
    chk("simul_head14", wb.gprWriteAddress_o, 14);
    tick();
    chk("simul_head15", wb.gprWriteAddress_o, 15);
    chk("simul_val15", wb.gprWriteVal_o, 64'hB4);
    tick();
    chk("simul_empty", count_o, 0);
    chk("simul_stall0", stall_o, 0);

    // Back-pressure fill and overflow drop
    wb.gprWriteReady_i = 1'b0;
    drive(1, 5'd1, 64'hA1, 0, 4'd0, 0, 0, 0, 0);
    tick();
    chk("bp_count1", count_o, 1);
    chk("bp_stall_c1", stall_o, 0);
    drive(1, 5'd2, 64'hA2, 0, 4'd0, 0, 0, 0, 0);
    tick();
    chk("bp_count2", count_o, 2);
    chk("bp_stall_c2", stall_o, 1);
    drive(1, 5'd3, 64'hA3, 0, 4'd0, 0, 0, 0, 0);
    tick();
    drive(1, 5'd4, 64'hA4, 0, 4'd0, 0, 0, 0, 0);
    tick();
    chk("bp_count4", count_o, 4);
    chk("bp_ovf0", overflowErr_o, 0);
    drive(1, 5'd9, 64'hA9, 0, 4'd0, 0, 0, 0, 0);
    tick();
    idle();
    chk("bp_drop_count", count_o, 4);
    chk("bp_drop_ovf", overflowErr_o, 1);
    chk("bp_head1", wb.gprWriteAddress_o, 1);
    chk("bp_val1", wb.gprWriteVal_o, 64'hA1);
    wb.gprWriteReady_i = 1'b1;
    tick();
    chk("drain_head2", wb.gprWriteAddress_o, 2);
    chk("drain_val2", wb.gprWriteVal_o, 64'hA2);
    chk("drain_count3", count_o, 3);
    tick();
    chk("drain_head3", wb.gprWriteAddress_o, 3);
    chk("drain_stall_c2", stall_o, 1);
    tick();
    chk("drain_head4", wb.gprWriteAddress_o, 4);
    chk("drain_stall_c1", stall_o, 0);
    tick();
    chk("drain_empty", count_o, 0);
    chk("drain_valid0", wb.gprWriteValid_o, 0);
    chk("drain_ovf_sticky", overflowErr_o, 1);

    // OV / SO / CR0
    drive(1, 5'd7, 64'h77, 1, 4'b1000, 1, 1, 0, 0);
    tick();
    idle();
    chk("ov1_crwe_pre", crWriteEnable_o, 0);
    tick();
    chk("ov1_ov", xerOV_o, 1);
    chk("ov1_so", xerSO_o, 1);
    chk("ov1_crwe", crWriteEnable_o, 1);
    chk("ov1_crfield", crField0_o, 4'b1001);
    drive(0, 5'd0, 64'h0, 0, 4'd0, 1, 0, 1, 1);
    tick();
    idle();
    chk("ov1_crwe_pulse", crWriteEnable_o, 0);
    tick();
    chk("ov0_ov", xerOV_o, 0);
    chk("ov0_so_sticky", xerSO_o, 1);
    chk("ov0_ca", xerCA_o, 1);
    chk("ov0_crwe", crWriteEnable_o, 0);
    chk("ov0_crfield_hold", crField0_o, 4'b1001);

    // Compare-only entry retires without ready
    wb.gprWriteReady_i = 1'b0;
    drive(0, 5'd3, 64'h0, 1, 4'b0010, 0, 0, 0, 0);
    tick();
    idle();
    chk("cmp_count1", count_o, 1);
    chk("cmp_gprvalid", wb.gprWriteValid_o, 0);
    tick();
    chk("cmp_count0", count_o, 0);
    chk("cmp_crwe", crWriteEnable_o, 1);
    chk("cmp_crfield", crField0_o, 4'b0011);
    tick();
    chk("cmp_crwe_off", crWriteEnable_o, 0);

    // Async reset mid-drain with 3 entries pending
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(20 + i), 64'(32'hC0 + i), 1, 4'b0100, 1, 1, 1, 0);
      tick();
    end
    idle();
    chk("ar_count3", count_o, 3);
    wb.gprWriteReady_i = 1'b1;
    #2;
    reset_i = 1'b0;
    #1;
    chk("ar_gprvalid", wb.gprWriteValid_o, 0);
    chk("ar_count", count_o, 0);
    chk("ar_crwe", crWriteEnable_o, 0);
    chk("ar_crfield", crField0_o, 0);
    chk("ar_so", xerSO_o, 0);
    chk("ar_ov", xerOV_o, 0);
    chk("ar_ca", xerCA_o, 0);
    chk("ar_stall", stall_o, 0);
    chk("ar_ovf", overflowErr_o, 0);
    tick(); tick();
    reset_i = 1'b1;
    tick();
    chk("ar_post_valid", wb.gprWriteValid_o, 0);
    chk("ar_post_count", count_o, 0);
    tick();
    chk("ar_post_crwe", crWriteEnable_o, 0);
    chk("ar_post_so", xerSO_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fx_writeback_queue.md
Name: fx_writeback_queue

Overview:
- Sits directly downstream of the fixed-point unit's stage-2 result registers.
- Buffers FX results in an in-order FIFO and drains them to the GPR file write port under a ready handshake.
- Owns the architectural XER bits SO, OV and CA, and produces condition-register field 0 writes, updated in program order at retire.
- The FX unit cannot stall, so the block raises an early back-pressure signal to dispatch before the FIFO can overflow.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥4).
- PTR_W, 2, log2(DEPTH).
- regWidth, 5, GPR address width.
- STALL_MARGIN, 2, free-entry threshold for stall (covers the 2-cycle FX pipeline).

Ports:
- clock_i  in  1  clock.
- reset_i  in  1  asynchronous active-low reset.
- resultValid_i  in  1  an FX result is present this cycle.
- functionalUnitCode_i  in  3  accepted only when equal to 0 (FX).
- regWriteEnable_i  in  1  result carries a GPR write.
- regWriteAddress_i  in  regWidth  GPR destination.
- regWriteVal_i  in  64  GPR data.
- updateCR0_i  in  1  result updates CR0.
- CR0_i  in  4  LT,GT,EQ,(bit3 ignored).
- updateOV_i  in  1  OE form: update OV, sticky-set SO.
- OV_i  in  1  new OV value.
- updateCA_i  in  1  carrying form: update CA.
- CA_i  in  1  new CA value.
- gprWriteReady_i  in  1  register file accepts the write this cycle.
- gprWriteValid_o  out  1  head entry has a GPR write pending.
- gprWriteAddress_o  out  regWidth  head destination.
- gprWriteVal_o  out  64  head data.
- crWriteEnable_o  out  1  one-cycle pulse, CR0 written.
- crField0_o  out  4  {LT,GT,EQ,SO}.
- xerSO_o, xerOV_o, xerCA_o  out  1 each  architectural XER bits.
- stall_o  out  1  dispatch must not issue FX ops.
- overflowErr_o  out  1  sticky, result dropped because FIFO full.
- count_o  out  PTR_W+1  occupancy.

Behaviour:
- Reset (async, reset_i=0):
  - FIFO empty; head/tail pointers and count_o = 0.
  - All outputs 0: gprWriteValid_o, crWriteEnable_o, crField0_o, xerSO/OV/CA, stall_o, overflowErr_o.
- Enqueue:
  - Condition: resultValid_i=1 and functionalUnitCode_i==0 and (count<DEPTH or a retire occurs the same cycle).
  - The entry stores all input fields.
  - A result with no update flags and regWriteEnable_i=0 is still enqueued, as a no-op entry.
- Full drop:
  - An enqueue condition with count==DEPTH and no retire that cycle drops the result and sets overflowErr_o.
  - overflowErr_o clears only on reset.
- Head presentation:
  - Write-port outputs are driven from the head entry register.
  - An entry enqueued in cycle N into an empty FIFO appears at cycle N+1.
  - gprWriteValid_o = head valid & head regWriteEnable.
- Retire:
  - Head retires when valid and (regWriteEnable==0 or gprWriteReady_i==1).
  - Non-GPR entries retire unconditionally in one cycle.
  - One retire per cycle, strictly in order.
- XER update, at the retire edge:
  - if updateCA then CA<=CA_i.
  - if updateOV then OV<=OV_i and SO<=SO|OV_i.
  - SO is never cleared except by reset.
- CR0 write:
  - On retire of an entry with updateCR0, crWriteEnable_o pulses high the cycle after retire.
  - crField0_o = {CR0[0:2], SO}, where SO is the value after that same entry's XER update.
- Stall:
  - stall_o registered; stall_o=1 when (DEPTH−count_next) ≤ STALL_MARGIN.
- Simultaneous enqueue and retire:
  - count unchanged.
  - Allowed at full; the new entry takes the freed slot.
- Pointers wrap modulo DEPTH.
- Reset mid-operation discards all pending entries; no partial XER/CR update.

Optional Feature:
- Macro: FXWB_FORWARD_EN.
- When defined, adds ports:
  - forwardAddr_i (in, regWidth).
  - forwardHit_o (out, 1).
  - forwardVal_o (out, 64).
- Lookup is combinational. It returns the youngest valid pending entry with regWriteEnable=1 and matching address, or hit=0 and val=0 if none. The head entry retiring this cycle still counts as a hit.
- When undefined, these ports and the compare logic are absent.

Test Plan:
- Single add, empty FIFO, ready=1:
  - Stimulus: regWriteEnable=1, addr=5, val=0x10, valid at cycle 0.
  - Response: gprWriteValid_o=1 with addr 5 / val 0x10 at cycle 1, retired at cycle 1 edge, count_o returns to 0.
- Back-pressure fill:
  - Stimulus: ready=0, four GPR results in consecutive cycles (DEPTH=4).
  - Response: stall_o=1 once 2 entries are held, count_o=4.
  - Stimulus: a fifth result.
  - Response: overflowErr_o=1, count_o stays 4. Drained order matches arrival.
- Full with simultaneous retire:
  - Stimulus: count=4, ready=1, new result.
  - Response: accepted, count_o stays 4, overflowErr_o remains 0.
- OV/SO/CR0:
  - Stimulus: updateOV=1, OV=1, updateCR0=1, CR0=4'b1000.
  - Response: xerOV=1, xerSO=1, crField0_o=4'b1001.
  - Stimulus: next entry updateOV=1, OV=0.
  - Response: OV=0, SO stays 1.
- Compare-only entry:
  - Stimulus: regWriteEnable=0, updateCR0=1, CR0=0010 while ready=0.
  - Response: retires without ready, crWriteEnable_o pulse, crField0_o=0010 with SO appended.
- Async reset:
  - Stimulus: reset_i low mid-drain with 3 entries pending.
  - Response: all outputs 0 immediately; no write after reset release.
